// File: rtl/uart_link_pkg.sv
// Shared types and constants for the two-board UART game link controller.
package uart_link_pkg;

  typedef enum logic [2:0] {
    StIdle      = 3'd0,
    StWaitPeer  = 3'd1,
    StPlaying   = 3'd2,
    StSendScore = 3'd3,
    StWaitScore = 3'd4,
    StDone      = 3'd5
  } link_state_e;

  localparam logic [7:0]  MSG_START        = 8'h53;
  localparam int unsigned SCORE_FLAG       = 7;
  localparam int unsigned DEF_RETRY_CYCLES = 7_500_000;
  localparam int unsigned DEF_MAX_RETRIES  = 50;

  function automatic logic [7:0] score_frame(input logic [6:0] score);
    return {1'b1, score};
  endfunction

endpackage

// File: rtl/uart_link_ctl_retry_timer.sv
// Retransmission timer: one-shot down-counter per attempt plus a count of resends.
module uart_link_ctl_retry_timer #(
  parameter int unsigned RETRY_CYCLES = 7_500_000,
  parameter int unsigned MAX_RETRIES  = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic run,
  input  logic restart,
  input  logic clear,
  output logic expire,
  output logic exhausted
);

  localparam int unsigned TW = $clog2(RETRY_CYCLES + 1);
  localparam int unsigned CW = $clog2(MAX_RETRIES + 1);

  logic [TW-1:0] timer_q;
  logic [CW-1:0] retries_q;

  // Timer parks at zero once it fires, so only a fresh restart can arm it again.
  assign expire    = run && !restart && (timer_q == TW'(1));
  assign exhausted = expire && (retries_q == CW'(MAX_RETRIES));

  always_ff @(posedge clk) begin
    if (rst) begin
      timer_q   <= '0;
      retries_q <= '0;
    end else begin
      if (!run) begin
        timer_q <= '0;
      end else if (restart) begin
        timer_q <= TW'(RETRY_CYCLES);
      end else if (timer_q != '0) begin
        timer_q <= timer_q - TW'(1);
      end

      if (clear) begin
        retries_q <= '0;
      end else if (expire && !exhausted) begin
        retries_q <= retries_q + CW'(1);
      end
    end
  end

endmodule

// File: rtl/uart_link_ctl.sv
// Sequences the start handshake and score exchange over a single UART byte channel.
module uart_link_ctl
  import uart_link_pkg::*;
#(
  parameter int unsigned RETRY_CYCLES = DEF_RETRY_CYCLES,
  parameter int unsigned MAX_RETRIES  = DEF_MAX_RETRIES
) (
  input  logic       pclk,
  input  logic       rst,
  input  logic       rect_clicked_play,
  input  logic       game_over,
  input  logic       restart,
  input  logic [6:0] my_score,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  input  logic       tx_busy,
  output logic       tx_start,
  output logic [7:0] tx_data,
  output logic       uart_start,
  output logic [6:0] op_score,
  output logic       op_score_valid,
  output logic       link_err
);

  link_state_e state_q, state_d;
  logic        peer_ready_q, peer_ready_d;
  logic        req_start_q, req_start_d;
  logic        req_score_q, req_score_d;
  logic        req_echo_q, req_echo_d;
  logic [7:0]  echo_byte_q, echo_byte_d;
  logic [6:0]  op_score_q, op_score_d;
  logic        op_valid_q, op_valid_d;
  logic        link_err_q, link_err_d;
  logic        uart_start_q, uart_start_d;
  logic        tx_start_q, tx_start_d1_q;
  logic [7:0]  tx_data_q, tx_data_d;

  logic       rx_start, rx_score, rx_accept;
  logic [7:0] my_frame;
  logic       grant, grant_start, grant_score;
  logic [7:0] grant_byte;
  logic       run, timer_restart, expire, exhausted;

  assign rx_start  = rx_valid && (rx_data == MSG_START);
  assign rx_score  = rx_valid && rx_data[SCORE_FLAG];
  assign rx_accept = rx_start || rx_score;
  assign my_frame  = score_frame(my_score);

  // Two-cycle gap after a grant hides the latency of tx_busy rising in the byte core.
  always_comb begin
    grant      = 1'b0;
    grant_byte = '0;
    if (!tx_busy && !tx_start_q && !tx_start_d1_q && !link_err_q) begin
      if (req_echo_q) begin
        grant      = 1'b1;
        grant_byte = echo_byte_q;
      end else if (req_score_q) begin
        grant      = 1'b1;
        grant_byte = my_frame;
      end else if (req_start_q) begin
        grant      = 1'b1;
        grant_byte = MSG_START;
      end
    end
  end

  assign grant_start = grant && (grant_byte == MSG_START);
  assign grant_score = grant && (grant_byte == my_frame);

  assign run           = (state_q == StWaitPeer) || (state_q == StWaitScore);
  assign timer_restart = grant || rx_accept;

  uart_link_ctl_retry_timer #(
    .RETRY_CYCLES(RETRY_CYCLES),
    .MAX_RETRIES (MAX_RETRIES)
  ) u_retry_timer (
    .clk      (pclk),
    .rst      (rst),
    .run      (run),
    .restart  (timer_restart),
    .clear    (state_d != state_q),
    .expire   (expire),
    .exhausted(exhausted)
  );

  always_comb begin
    state_d      = state_q;
    peer_ready_d = peer_ready_q;
    req_start_d  = req_start_q;
    req_score_d  = req_score_q;
    req_echo_d   = req_echo_q;
    echo_byte_d  = echo_byte_q;
    op_score_d   = op_score_q;
    op_valid_d   = op_valid_q;
    link_err_d   = link_err_q;
    uart_start_d = 1'b0;
    tx_data_d    = grant ? grant_byte : tx_data_q;

    // One grant retires every pending request for the same byte.
    if (grant) begin
      if (echo_byte_q == grant_byte) req_echo_d = 1'b0;
      if (my_frame == grant_byte)    req_score_d = 1'b0;
      if (grant_byte == MSG_START)   req_start_d = 1'b0;
    end

    unique case (state_q)
      StIdle: begin
        if (rx_start) peer_ready_d = 1'b1;
        if (rect_clicked_play && !link_err_q) begin
          req_start_d = 1'b1;
          state_d     = StWaitPeer;
        end
      end
      StWaitPeer: begin
        if (expire) req_start_d = 1'b1;
        if (grant_start && peer_ready_q) begin
          uart_start_d = 1'b1;
          state_d      = StPlaying;
        end else if (rx_start) begin
          peer_ready_d = 1'b1;
          req_start_d  = 1'b1;
        end
      end
      StPlaying: begin
        if (rx_start) begin
          req_echo_d  = 1'b1;
          echo_byte_d = MSG_START;
        end
        if (rx_score) begin
          op_score_d = rx_data[6:0];
          op_valid_d = 1'b1;
        end
        if (game_over) state_d = StSendScore;
      end
      StSendScore: begin
        req_score_d = 1'b1;
        state_d     = StWaitScore;
        if (rx_score) begin
          op_score_d = rx_data[6:0];
          op_valid_d = 1'b1;
        end
      end
      StWaitScore: begin
        if (expire) req_score_d = 1'b1;
        if (rx_score) begin
          op_score_d = rx_data[6:0];
          op_valid_d = 1'b1;
          state_d    = StDone;
        end else if (op_valid_q && grant_score) begin
          state_d = StDone;
        end
      end
      StDone: begin
        if (rx_score) begin
          req_echo_d  = 1'b1;
          echo_byte_d = my_frame;
          if (rx_data[6:0] != op_score_q) op_score_d = rx_data[6:0];
        end
        if (restart) begin
          op_valid_d   = 1'b0;
          peer_ready_d = 1'b0;
          state_d      = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    if (exhausted) begin
      link_err_d  = 1'b1;
      state_d     = StIdle;
      req_start_d = 1'b0;
      req_score_d = 1'b0;
      req_echo_d  = 1'b0;
    end
  end

  always_ff @(posedge pclk) begin
    if (rst) begin
      state_q       <= StIdle;
      peer_ready_q  <= 1'b0;
      req_start_q   <= 1'b0;
      req_score_q   <= 1'b0;
      req_echo_q    <= 1'b0;
      echo_byte_q   <= '0;
      op_score_q    <= '0;
      op_valid_q    <= 1'b0;
      link_err_q    <= 1'b0;
      uart_start_q  <= 1'b0;
      tx_start_q    <= 1'b0;
      tx_start_d1_q <= 1'b0;
      tx_data_q     <= '0;
    end else begin
      state_q       <= state_d;
      peer_ready_q  <= peer_ready_d;
      req_start_q   <= req_start_d;
      req_score_q   <= req_score_d;
      req_echo_q    <= req_echo_d;
      echo_byte_q   <= echo_byte_d;
      op_score_q    <= op_score_d;
      op_valid_q    <= op_valid_d;
      link_err_q    <= link_err_d;
      uart_start_q  <= uart_start_d;
      tx_start_q    <= grant;
      tx_start_d1_q <= tx_start_q;
      tx_data_q     <= tx_data_d;
    end
  end

  assign tx_start       = tx_start_q;
  assign tx_data        = tx_data_q;
  assign uart_start     = uart_start_q;
  assign op_score       = op_score_q;
  assign op_score_valid = op_valid_q;
  assign link_err       = link_err_q;

endmodule

// File: tb/tb_uart_link_ctl.sv
// Bench for uart_link_ctl: scoreboard of expected TX bytes against a negedge TX monitor.
module tb_uart_link_ctl;
  import uart_link_pkg::*;

  localparam int unsigned RC = 100;
  localparam int unsigned MR = 3;

  logic       pclk = 1'b0;
  logic       rst = 1'b1;
  logic       rect_clicked_play = 1'b0;
  logic       game_over = 1'b0;
  logic       restart = 1'b0;
  logic [6:0] my_score = '0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = '0;
  logic       hold_busy = 1'b0;
  logic       tx_busy;
  logic       tx_start;
  logic [7:0] tx_data;
  logic       uart_start;
  logic [6:0] op_score;
  logic       op_score_valid;
  logic       link_err;

  int checks = 0;
  int passes = 0;
  int cyc = 0;
  int busy_cnt = 0;
  int tx_count = 0;
  int rd = 0;
  logic [7:0] obs_data [64];
  int         obs_cyc [64];
  logic [7:0] exp_q [$];

  uart_link_ctl #(
    .RETRY_CYCLES(RC),
    .MAX_RETRIES (MR)
  ) dut (
    .pclk             (pclk),
    .rst              (rst),
    .rect_clicked_play(rect_clicked_play),
    .game_over        (game_over),
    .restart          (restart),
    .my_score         (my_score),
    .rx_valid         (rx_valid),
    .rx_data          (rx_data),
    .tx_busy          (tx_busy),
    .tx_start         (tx_start),
    .tx_data          (tx_data),
    .uart_start       (uart_start),
    .op_score         (op_score),
    .op_score_valid   (op_score_valid),
    .link_err         (link_err)
  );

  always #5 pclk = ~pclk;

  always @(posedge pclk) cyc <= cyc + 1;

  // Byte-core model: busy for 10 cycles after each tx_start; not reset by rst.
  always @(posedge pclk) begin
    if (tx_start === 1'b1) busy_cnt <= 10;
    else if (busy_cnt != 0) busy_cnt <= busy_cnt - 1;
  end
  assign tx_busy = (busy_cnt != 0) || hold_busy;

  always @(negedge pclk) begin
    if (tx_start === 1'b1 && tx_count < 64) begin
      obs_data[tx_count] <= tx_data;
      obs_cyc[tx_count]  <= cyc;
      tx_count           <= tx_count + 1;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout want summary");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge pclk);
    #1;
  endtask

  task automatic pulse_rx(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    repeat (12) step();
    hold_busy = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    rd = tx_count;
  endtask

  task automatic bring_up();
    do_reset();
    pulse_rx(MSG_START);
    rect_clicked_play = 1'b1;
    step();
    rect_clicked_play = 1'b0;
    exp_q.push_back(MSG_START);
    repeat (3) step();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) step();
    checks++; if (tx_start !== 1'b0) $display("FAIL reset_tx_start got %b want 0", tx_start); else passes++;
    checks++; if (tx_data !== 8'h00) $display("FAIL reset_tx_data got %h want 00", tx_data); else passes++;
    checks++; if (uart_start !== 1'b0) $display("FAIL reset_uart_start got %b want 0", uart_start); else passes++;
    checks++; if (op_score !== 7'd0) $display("FAIL reset_op_score got %0d want 0", op_score); else passes++;
    checks++; if (op_score_valid !== 1'b0) $display("FAIL reset_op_valid got %b want 0", op_score_valid); else passes++;
    checks++; if (link_err !== 1'b0) $display("FAIL reset_link_err got %b want 0", link_err); else passes++;
    checks++; if (dut.state_q !== StIdle) $display("FAIL reset_state got %0d want %0d", dut.state_q, StIdle); else passes++;
    rst = 1'b0;
    rd = tx_count;
  endtask

  task automatic test_handshake();
    logic [7:0] e;
    logic [8:0] got;
    do_reset();
    pulse_rx(MSG_START);
    step();
    rect_clicked_play = 1'b1;
    step();
    rect_clicked_play = 1'b0;
    exp_q.push_back(MSG_START);
    step();
    checks++; if (tx_start !== 1'b1) $display("FAIL hs_latency tx_start got %b want 1", tx_start); else passes++;
    checks++; if (uart_start !== 1'b1) $display("FAIL hs_uart_start got %b want 1", uart_start); else passes++;
    checks++; if (dut.state_q !== StPlaying) $display("FAIL hs_state got %0d want %0d", dut.state_q, StPlaying); else passes++;
    step();
    checks++; if (uart_start !== 1'b0) $display("FAIL hs_uart_start_pulse got %b want 0", uart_start); else passes++;
    repeat (30) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (rd < tx_count) ? {1'b0, obs_data[rd]} : 9'h1FF;
      rd++;
      checks++; if (got !== {1'b0, e}) $display("FAIL hs_tx got %h want %h", got, e); else passes++;
    end
    checks++; if (tx_count != rd) $display("FAIL hs_tx_count got %0d want %0d", tx_count, rd); else passes++;
    rd = tx_count;
  endtask

  task automatic test_retry();
    int n;
    int base;
    int gap;
    logic [7:0] e;
    logic [8:0] got;
    do_reset();
    base = rd;
    rect_clicked_play = 1'b1;
    step();
    rect_clicked_play = 1'b0;
    repeat (1 + MR) exp_q.push_back(MSG_START);
    n = 0;
    while (link_err !== 1'b1 && n < 800) begin step(); n++; end
    checks++; if (link_err !== 1'b1) $display("FAIL retry_link_err got %b want 1", link_err); else passes++;
    checks++; if (dut.state_q !== StIdle) $display("FAIL retry_state got %0d want %0d", dut.state_q, StIdle); else passes++;
    repeat (300) step();
    gap = (tx_count >= base + 2) ? obs_cyc[base+1] - obs_cyc[base] : -1;
    checks++;
    if (gap < int'(RC) || gap > int'(RC) + 3) $display("FAIL retry_period got %0d want %0d..%0d", gap, RC, RC + 3);
    else passes++;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (rd < tx_count) ? {1'b0, obs_data[rd]} : 9'h1FF;
      rd++;
      checks++; if (got !== {1'b0, e}) $display("FAIL retry_tx got %h want %h", got, e); else passes++;
    end
    checks++; if (tx_count != rd) $display("FAIL retry_tx_count got %0d want %0d", tx_count, rd); else passes++;
    rd = tx_count;
  endtask

  task automatic test_score_exchange();
    int n;
    logic [7:0] e;
    logic [8:0] got;
    bring_up();
    my_score = 7'd42;
    checks++; if (op_score_valid !== 1'b0) $display("FAIL sx_valid_before got %b want 0", op_score_valid); else passes++;
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    exp_q.push_back(8'hAA);
    n = 0;
    while (tx_start !== 1'b1 && n < 40) begin step(); n++; end
    checks++; if (tx_start !== 1'b1) $display("FAIL sx_tx_seen got %b want 1", tx_start); else passes++;
    repeat (3) step();
    pulse_rx(8'h97);
    checks++; if (op_score !== 7'd23) $display("FAIL sx_op_score got %0d want 23", op_score); else passes++;
    checks++; if (op_score_valid !== 1'b1) $display("FAIL sx_op_valid got %b want 1", op_score_valid); else passes++;
    checks++; if (dut.state_q !== StDone) $display("FAIL sx_state got %0d want %0d", dut.state_q, StDone); else passes++;
    repeat (20) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (rd < tx_count) ? {1'b0, obs_data[rd]} : 9'h1FF;
      rd++;
      checks++; if (got !== {1'b0, e}) $display("FAIL sx_tx got %h want %h", got, e); else passes++;
    end
    checks++; if (tx_count != rd) $display("FAIL sx_tx_count got %0d want %0d", tx_count, rd); else passes++;
    rd = tx_count;
  endtask

  // Runs in DONE after test_score_exchange: two score frames while busy merge into one echo.
  task automatic test_back_to_back();
    logic [7:0] e;
    logic [8:0] got;
    hold_busy = 1'b1;
    pulse_rx(8'h97);
    step();
    pulse_rx(8'h98);
    exp_q.push_back(8'hAA);
    repeat (3) step();
    checks++; if (op_score !== 7'd24) $display("FAIL b2b_op_update got %0d want 24", op_score); else passes++;
    hold_busy = 1'b0;
    repeat (40) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (rd < tx_count) ? {1'b0, obs_data[rd]} : 9'h1FF;
      rd++;
      checks++; if (got !== {1'b0, e}) $display("FAIL b2b_echo got %h want %h", got, e); else passes++;
    end
    checks++; if (tx_count != rd) $display("FAIL b2b_echo_count got %0d want %0d", tx_count, rd); else passes++;
    rd = tx_count;
    restart = 1'b1;
    step();
    restart = 1'b0;
    checks++; if (op_score_valid !== 1'b0) $display("FAIL restart_valid got %b want 0", op_score_valid); else passes++;
    checks++; if (dut.state_q !== StIdle) $display("FAIL restart_state got %0d want %0d", dut.state_q, StIdle); else passes++;
  endtask

  task automatic test_early_score();
    int n;
    logic [7:0] e;
    logic [8:0] got;
    bring_up();
    pulse_rx(8'h85);
    checks++; if (op_score !== 7'd5) $display("FAIL early_op_score got %0d want 5", op_score); else passes++;
    checks++; if (op_score_valid !== 1'b1) $display("FAIL early_op_valid got %b want 1", op_score_valid); else passes++;
    my_score = 7'd9;
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    exp_q.push_back(8'h89);
    n = 0;
    while (tx_start !== 1'b1 && n < 40) begin step(); n++; end
    checks++; if (dut.state_q !== StDone) $display("FAIL early_done got %0d want %0d", dut.state_q, StDone); else passes++;
    repeat (250) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (rd < tx_count) ? {1'b0, obs_data[rd]} : 9'h1FF;
      rd++;
      checks++; if (got !== {1'b0, e}) $display("FAIL early_tx got %h want %h", got, e); else passes++;
    end
    checks++; if (tx_count != rd) $display("FAIL early_tx_count got %0d want %0d", tx_count, rd); else passes++;
    rd = tx_count;
  endtask

  task automatic test_rx_wins();
    int n;
    logic [7:0] e;
    logic [8:0] got;
    bring_up();
    my_score = 7'd42;
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    exp_q.push_back(8'hAA);
    n = 0;
    while (tx_start !== 1'b1 && n < 40) begin step(); n++; end
    // Land rx_valid on the exact cycle the retry timer expires.
    repeat (RC - 1) step();
    pulse_rx(8'h97);
    checks++; if (dut.state_q !== StDone) $display("FAIL rxwin_state got %0d want %0d", dut.state_q, StDone); else passes++;
    checks++; if (op_score !== 7'd23) $display("FAIL rxwin_op_score got %0d want 23", op_score); else passes++;
    repeat (40) step();
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      got = (rd < tx_count) ? {1'b0, obs_data[rd]} : 9'h1FF;
      rd++;
      checks++; if (got !== {1'b0, e}) $display("FAIL rxwin_tx got %h want %h", got, e); else passes++;
    end
    checks++; if (tx_count != rd) $display("FAIL rxwin_no_retry got %0d want %0d", tx_count, rd); else passes++;
    rd = tx_count;
  endtask

  task automatic test_reset_mid();
    int n;
    bring_up();
    my_score = 7'd42;
    game_over = 1'b1;
    step();
    game_over = 1'b0;
    n = 0;
    while (tx_start !== 1'b1 && n < 40) begin step(); n++; end
    hold_busy = 1'b1;
    rst = 1'b1;
    step();
    checks++; if (tx_start !== 1'b0) $display("FAIL rmid_tx_start got %b want 0", tx_start); else passes++;
    checks++; if (tx_data !== 8'h00) $display("FAIL rmid_tx_data got %h want 00", tx_data); else passes++;
    checks++; if (uart_start !== 1'b0) $display("FAIL rmid_uart_start got %b want 0", uart_start); else passes++;
    checks++; if (op_score_valid !== 1'b0) $display("FAIL rmid_op_valid got %b want 0", op_score_valid); else passes++;
    checks++; if (link_err !== 1'b0) $display("FAIL rmid_link_err got %b want 0", link_err); else passes++;
    checks++; if (dut.state_q !== StIdle) $display("FAIL rmid_state got %0d want %0d", dut.state_q, StIdle); else passes++;
    rst = 1'b0;
    hold_busy = 1'b0;
    exp_q.delete();
    repeat (5) step();
    rd = tx_count;
  endtask

  initial begin
    test_reset();
    test_handshake();
    test_retry();
    test_score_exchange();
    test_back_to_back();
    test_early_score();
    test_rx_wins();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
